// File: rtl/cam_seq_pkg.sv
// Shared types and sizing helpers for the sequential CAM search block.
package cam_seq_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, RESP} cam_seq_state_t;

  // Index width for a given entry count; at least one bit so ports stay legal.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/cam_seq_search_eql_cmp.sv
// Single combinational equality comparator shared by every scan step.
module eql_cmp #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] val,
  input  logic [WIDTH-1:0] rfr,
  output logic             eql
);

  assign eql = (val == rfr);

endmodule

// File: rtl/cam_seq_search.sv
// Sequential CAM search: scans entries from index 0 upward, one per clock,
// and returns the lowest valid match (or a miss) through a valid/ready response.
module cam_seq_search
  import cam_seq_pkg::*;
#(
  parameter  int WIDTH     = 4,
  parameter  int DEPTH     = 8,
  localparam int DEPTH_LOG = idx_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_vld,
  input  logic [DEPTH_LOG-1:0] wr_adr,
  input  logic [WIDTH-1:0]     wr_dat,
  input  logic                 clr,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [WIDTH-1:0]     req_key,
  output logic                 rsp_vld,
  input  logic                 rsp_rdy,
  output logic                 rsp_hit,
  output logic [DEPTH_LOG-1:0] rsp_idx
);

  cam_seq_state_t       state_q, state_d;
  logic [DEPTH_LOG-1:0] idx_q, idx_d;
  logic [DEPTH_LOG-1:0] ridx_q, ridx_d;
  logic                 hit_q, hit_d;
  logic [WIDTH-1:0]     key_q;
  logic [WIDTH-1:0]     ent [DEPTH];
  logic [DEPTH-1:0]     vld;
  logic                 key_load;
  logic                 eql;
  logic                 match;
  logic                 last;
  logic                 wr_ok;

  eql_cmp #(.WIDTH(WIDTH)) u_eql_cmp (
    .val (key_q),
    .rfr (ent[idx_q]),
    .eql (eql)
  );

  assign match = eql & vld[idx_q];
  assign last  = (idx_q == DEPTH_LOG'(DEPTH - 1));
  assign wr_ok = wr_vld && ({1'b0, wr_adr} < (DEPTH_LOG + 1)'(DEPTH));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    ridx_d   = ridx_q;
    key_load = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_vld) begin
          key_load = 1'b1;
          idx_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          hit_d   = 1'b1;
          ridx_d  = idx_q;
          state_d = RESP;
        end else if (last) begin
          hit_d   = 1'b0;
          ridx_d  = '0;
          state_d = RESP;
        end else begin
          idx_d = idx_q + DEPTH_LOG'(1);
        end
      end
      RESP: begin
        if (rsp_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      ridx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      ridx_q  <= ridx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (key_load) key_q <= req_key;
  end

  // Clear then write: the later non-blocking assignment leaves only the written bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
    end else begin
      if (clr)   vld         <= '0;
      if (wr_ok) vld[wr_adr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) ent[wr_adr] <= wr_dat;
  end

  assign req_rdy = (state_q == IDLE);
  assign rsp_vld = (state_q == RESP);
  assign rsp_hit = hit_q;
  assign rsp_idx = ridx_q;

endmodule
